// File: rtl/irq_pkg.sv
// Shared types and default constants for the interrupt controller.
package irq_pkg;

    localparam int MAX_IRQ = 8;
    localparam int IDX_W   = 3;

    localparam logic [7:0]  DEF_VEC_BASE   = 8'h40;
    localparam logic [7:0]  DEF_VEC_STRIDE = 8'h08;
    localparam logic [15:0] DEF_IE_ADDR    = 16'hFFFF;
    localparam logic [15:0] DEF_IF_ADDR    = 16'hFF0F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_controller_if.sv
// Register bus plus sequencer handshake for the interrupt controller.
interface irq_controller_if #(
    parameter int NUM_IRQ = 5
);
    logic [15:0]        A;
    logic [7:0]         DI;
    logic [7:0]         DO;
    logic               DO_EN;
    logic               RD;
    logic               WR;
    logic [NUM_IRQ-1:0] IRQ_TRIG;
    logic               IME_SET;
    logic               IME_CLR;
    logic               IRQ_REQ;
    logic               IRQ_ACK;
    logic [7:0]         VEC;
    logic [NUM_IRQ-1:0] IRQ_CLR;
    logic               WAKE;

    modport master (
        output A, DI, RD, WR, IRQ_TRIG, IME_SET, IME_CLR, IRQ_ACK,
        input  DO, DO_EN, IRQ_REQ, VEC, IRQ_CLR, WAKE
    );

    modport slave (
        input  A, DI, RD, WR, IRQ_TRIG, IME_SET, IME_CLR, IRQ_ACK,
        output DO, DO_EN, IRQ_REQ, VEC, IRQ_CLR, WAKE
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: any, binary index, one-hot.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = 5
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               any,
    output logic [IDX_W-1:0]   index,
    output logic [NUM_IRQ-1:0] onehot
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        any    = |req;
        index  = '0;
        onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index     = i[IDX_W-1:0];
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: IE/IF registers, IME with EI delay, REQ/ACK sequencer.
// Define IRQ_EDGE_DETECT_EN for rising-edge triggers (default: level).
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ    = 5,
    parameter logic [7:0]  VEC_BASE   = DEF_VEC_BASE,
    parameter logic [7:0]  VEC_STRIDE = DEF_VEC_STRIDE,
    parameter logic [15:0] IE_ADDR    = DEF_IE_ADDR,
    parameter logic [15:0] IF_ADDR    = DEF_IF_ADDR
) (
    input  logic             CLK,
    input  logic             RES,
    irq_controller_if.slave  bus
);

    logic [NUM_IRQ-1:0] ie_q;
    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] if_nxt;
    logic [NUM_IRQ-1:0] set_ev;
    logic [NUM_IRQ-1:0] pend;
    logic               ime;
    logic               ime_pipe;
    irq_state_e         state;
    logic [7:0]         vec_q;

    logic               win_any;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_IRQ-1:0] win_oh;
    logic [7:0]         vec_cur;
    logic               ack;
    logic               wr_ie;
    logic               wr_if;
    logic               rd_ie;
    logic               rd_if;
    logic [7:0]         ie8;
    logic [7:0]         if8;

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] trig_prev;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) trig_prev <= '0;
        else     trig_prev <= bus.IRQ_TRIG;
    end

    assign set_ev = bus.IRQ_TRIG & ~trig_prev;
`else
    assign set_ev = bus.IRQ_TRIG;
`endif

    assign pend = ie_q & if_q;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
        .req    (pend),
        .any    (win_any),
        .index  (win_idx),
        .onehot (win_oh)
    );

    assign vec_cur = VEC_BASE + {{(8-IDX_W){1'b0}}, win_idx} * VEC_STRIDE;
    assign ack     = (state == REQ) && bus.IRQ_ACK;

    assign wr_ie = bus.WR && (bus.A == IE_ADDR);
    assign wr_if = bus.WR && (bus.A == IF_ADDR);
    assign rd_ie = bus.RD && (bus.A == IE_ADDR);
    assign rd_if = bus.RD && (bus.A == IF_ADDR) && !rd_ie;

    always_comb begin
        ie8 = '1;
        if8 = '1;
        ie8[NUM_IRQ-1:0] = ie_q;
        if8[NUM_IRQ-1:0] = if_q;
    end

    assign bus.DO_EN = rd_ie || rd_if;
    assign bus.DO    = rd_ie ? ie8 : (rd_if ? if8 : 8'hFF);

    assign bus.IRQ_REQ = (state == REQ);
    assign bus.VEC     = (state == REQ) ? vec_cur : vec_q;
    assign bus.IRQ_CLR = ack ? win_oh : '0;
    assign bus.WAKE    = |pend;

    // A new trigger in the same cycle overrides both a write and an ack clear.
    always_comb begin
        if_nxt = if_q;
        if (wr_if) if_nxt = bus.DI[NUM_IRQ-1:0];
        if (ack)   if_nxt = if_nxt & ~win_oh;
        if_nxt = if_nxt | set_ev;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ie_q <= '0;
            if_q <= '0;
        end else begin
            if (wr_ie) ie_q <= bus.DI[NUM_IRQ-1:0];
            if_q <= if_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ime      <= 1'b0;
            ime_pipe <= 1'b0;
        end else if (bus.IME_CLR || ack) begin
            ime      <= 1'b0;
            ime_pipe <= 1'b0;
        end else begin
            ime_pipe <= bus.IME_SET;
            if (ime_pipe) ime <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state <= IDLE;
            vec_q <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ime && win_any) state <= REQ;
                end
                REQ: begin
                    if (bus.IRQ_ACK) begin
                        state <= ACKD;
                        vec_q <= win_any ? vec_cur : 8'h00;
                    end else if (!ime) begin
                        state <= IDLE;
                    end
                end
                ACKD: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed checks of irq_controller with NUM_IRQ=5 and default vectors/addresses.
module tb_irq_controller;

    logic clk;
    logic res;
    int   errors;
    int   checks;

    irq_controller_if #(.NUM_IRQ(5)) bus ();

    irq_controller #(.NUM_IRQ(5)) dut (
        .CLK (clk),
        .RES (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        bus.A  = addr;
        bus.DI = data;
        bus.WR = 1'b1;
        step();
        bus.WR = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        bus.A  = addr;
        bus.RD = 1'b1;
        #1;
        check({tag, "_en"}, {7'b0, bus.DO_EN}, 8'h01);
        check(tag, bus.DO, exp);
        bus.RD = 1'b0;
    endtask

    task automatic ime_on();
        bus.IME_SET = 1'b1;
        step();
        bus.IME_SET = 1'b0;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        res = 1'b1;
        bus.A = 16'h0000;
        bus.DI = 8'h00;
        bus.RD = 1'b0;
        bus.WR = 1'b0;
        bus.IRQ_TRIG = '0;
        bus.IME_SET = 1'b0;
        bus.IME_CLR = 1'b0;
        bus.IRQ_ACK = 1'b0;
        step();
        step();

        check("rst_req", {7'b0, bus.IRQ_REQ}, 8'h00);
        check("rst_clr", {3'b0, bus.IRQ_CLR}, 8'h00);
        check("rst_wake", {7'b0, bus.WAKE}, 8'h00);
        check("rst_vec", bus.VEC, 8'h00);
        check("rst_doen", {7'b0, bus.DO_EN}, 8'h00);
        check("rst_do", bus.DO, 8'hFF);
        res = 1'b0;
        step();
        rd("rst_ie", 16'hFFFF, 8'hE0);
        rd("rst_if", 16'hFF0F, 8'hE0);

        bus.A = 16'h1234;
        bus.RD = 1'b1;
        #1;
        check("rd_miss_en", {7'b0, bus.DO_EN}, 8'h00);
        check("rd_miss_do", bus.DO, 8'hFF);
        bus.RD = 1'b0;

        // Basic dispatch: two sources pending, bit 1 wins.
        wr(16'hFFFF, 8'h1F);
        rd("ie_all", 16'hFFFF, 8'hFF);
        ime_on();
        step();
        check("idle_noreq", {7'b0, bus.IRQ_REQ}, 8'h00);
        bus.IRQ_TRIG = 5'b00110;
        step();
        bus.IRQ_TRIG = 5'b00000;
        check("trig_wake", {7'b0, bus.WAKE}, 8'h01);
        check("trig_still_idle", {7'b0, bus.IRQ_REQ}, 8'h00);
        step();
        check("req_up", {7'b0, bus.IRQ_REQ}, 8'h01);
        check("req_vec", bus.VEC, 8'h48);
        bus.IRQ_ACK = 1'b1;
        #1;
        check("ack_clr", {3'b0, bus.IRQ_CLR}, 8'h02);
        step();
        bus.IRQ_ACK = 1'b0;
        #1;
        check("ackd_req", {7'b0, bus.IRQ_REQ}, 8'h00);
        check("ackd_vec", bus.VEC, 8'h48);
        check("ackd_clr", {3'b0, bus.IRQ_CLR}, 8'h00);
        rd("ackd_if", 16'hFF0F, 8'hE4);
        step();
        step();
        check("ime_cleared", {7'b0, bus.IRQ_REQ}, 8'h00);
        check("idle_wake", {7'b0, bus.WAKE}, 8'h01);

        // EI delay: request appears on the third cycle after IME_SET.
        wr(16'hFFFF, 8'h01);
        wr(16'hFF0F, 8'h01);
        bus.IME_SET = 1'b1;
        step();
        bus.IME_SET = 1'b0;
        check("ei_t1", {7'b0, bus.IRQ_REQ}, 8'h00);
        step();
        check("ei_t2", {7'b0, bus.IRQ_REQ}, 8'h00);
        step();
        check("ei_t3", {7'b0, bus.IRQ_REQ}, 8'h01);
        check("ei_vec", bus.VEC, 8'h40);

        // Cancel: pending cleared by a bus write before the ack.
        wr(16'hFF0F, 8'h00);
        check("cancel_req", {7'b0, bus.IRQ_REQ}, 8'h01);
        check("cancel_wake", {7'b0, bus.WAKE}, 8'h00);
        bus.IRQ_ACK = 1'b1;
        #1;
        check("cancel_clr", {3'b0, bus.IRQ_CLR}, 8'h00);
        step();
        bus.IRQ_ACK = 1'b0;
        check("cancel_vec", bus.VEC, 8'h00);
        check("cancel_ackd", {7'b0, bus.IRQ_REQ}, 8'h00);
        step();

        // IME off, enabled source pending: wake without request.
        bus.IRQ_TRIG = 5'b00001;
        step();
        bus.IRQ_TRIG = 5'b00000;
        step();
        step();
        check("wake_only", {7'b0, bus.WAKE}, 8'h01);
        check("wake_noreq", {7'b0, bus.IRQ_REQ}, 8'h00);
        rd("wake_if", 16'hFF0F, 8'hE1);

        // New trigger on the acked source wins over its clear.
        wr(16'hFFFF, 8'h1F);
        wr(16'hFF0F, 8'h04);
        ime_on();
        step();
        check("race_req", {7'b0, bus.IRQ_REQ}, 8'h01);
        check("race_vec", bus.VEC, 8'h50);
        bus.IRQ_TRIG = 5'b00100;
        bus.IRQ_ACK = 1'b1;
        #1;
        check("race_clr", {3'b0, bus.IRQ_CLR}, 8'h04);
        step();
        bus.IRQ_TRIG = 5'b00000;
        bus.IRQ_ACK = 1'b0;
        rd("race_if", 16'hFF0F, 8'hE4);
        check("race_vecq", bus.VEC, 8'h50);
        step();

        // Ack outside REQ does nothing.
        bus.IRQ_ACK = 1'b1;
        #1;
        check("stray_ack_clr", {3'b0, bus.IRQ_CLR}, 8'h00);
        step();
        bus.IRQ_ACK = 1'b0;
        rd("stray_ack_if", 16'hFF0F, 8'hE4);

        // IME_CLR while requesting withdraws the request.
        ime_on();
        step();
        check("di_req", {7'b0, bus.IRQ_REQ}, 8'h01);
        bus.IME_CLR = 1'b1;
        step();
        bus.IME_CLR = 1'b0;
        step();
        check("di_drop", {7'b0, bus.IRQ_REQ}, 8'h00);

        // Simultaneous EI and DI: DI wins.
        bus.IME_SET = 1'b1;
        bus.IME_CLR = 1'b1;
        step();
        bus.IME_SET = 1'b0;
        bus.IME_CLR = 1'b0;
        step();
        step();
        step();
        check("ei_di_same", {7'b0, bus.IRQ_REQ}, 8'h00);

        // Reset mid-handshake, trigger held across release.
        ime_on();
        step();
        check("rst_pre_req", {7'b0, bus.IRQ_REQ}, 8'h01);
        bus.IRQ_TRIG = 5'b00001;
        res = 1'b1;
        #1;
        check("rst_mid_req", {7'b0, bus.IRQ_REQ}, 8'h00);
        check("rst_mid_vec", bus.VEC, 8'h00);
        check("rst_mid_clr", {3'b0, bus.IRQ_CLR}, 8'h00);
        step();
        res = 1'b0;
        check("rst_mid_req2", {7'b0, bus.IRQ_REQ}, 8'h00);
        step();
        bus.IRQ_TRIG = 5'b00000;
        rd("rst_rel_ie", 16'hFFFF, 8'hE0);
        rd("rst_rel_if", 16'hFF0F, 8'hE1);
        check("rst_rel_wake", {7'b0, bus.WAKE}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 5, number of interrupt sources (1..8).
REQ-002 SHALL have parameter VEC_BASE, default 8'h40, vector of source 0.
REQ-003 SHALL have parameter VEC_STRIDE, default 8'h08, vector spacing per source.
REQ-004 SHALL have parameter IE_ADDR, default 16'hFFFF, IE register address.
REQ-005 SHALL have parameter IF_ADDR, default 16'hFF0F, IF register address.
REQ-006 SHALL have ports:
- CLK in 1: single clock, all state on rising edge.
- RES in 1: reset, asynchronous, active-high.
- A in 16: address bus.
- DI in 8: write data.
- DO out 8: read data.
- DO_EN out 1: DO valid.
- RD in 1: read strobe.
- WR in 1: write strobe.
- IRQ_TRIG in NUM_IRQ: source requests.
- IME_SET in 1: EI pulse.
- IME_CLR in 1: DI pulse.
- IRQ_REQ out 1: interrupt request to sequencer.
- IRQ_ACK in 1: sequencer takes interrupt.
- VEC out 8: dispatch vector.
- IRQ_CLR out NUM_IRQ: one-hot acknowledged source.
- WAKE out 1: HALT exit.

Function
REQ-007 SHALL hold registers IE[NUM_IRQ-1:0], IF[NUM_IRQ-1:0], IME, IME_PIPE, state, VEC_Q.
REQ-008 Bus read: DO_EN=RD&(A==IE_ADDR|A==IF_ADDR), combinational. DO={unimplemented bits=1, IE or IF}. DO=8'hFF when DO_EN=0.
REQ-009 Bus write: WR with A==IE_ADDR loads IE from DI[NUM_IRQ-1:0] next edge. WR with A==IF_ADDR loads IF the same way.
REQ-010 IF set event per bit: trigger condition (REQ-025). Set OR-merges over a same-cycle bus write and over an ack clear. Set wins.
REQ-011 PEND=IE&IF. Priority is lowest index highest.
REQ-012 VEC=VEC_BASE+idx*VEC_STRIDE, truncated to 8 bits (wraps).
REQ-013 WAKE=|PEND, combinational, independent of IME and state.
REQ-014 FSM IDLE: to REQ when IME&|PEND.
REQ-015 FSM REQ: IRQ_REQ=1, VEC tracks current winner combinationally. On IRQ_ACK go to ACKD.
REQ-016 At the ACK cycle, winner k: capture VEC_Q, IRQ_CLR=1<<k for one cycle, clear IF[k] next edge, clear IME and IME_PIPE next edge.
REQ-017 Cancel at ACK: PEND==0 in the ACK cycle gives VEC_Q=8'h00, IRQ_CLR=0, no IF change, IME still cleared.
REQ-018 FSM ACKD: VEC=VEC_Q, IRQ_REQ=0. Return to IDLE next cycle.
REQ-019 FSM REQ with IME cleared by IME_CLR before ACK: return to IDLE, IRQ_REQ drops next cycle.
REQ-020 IME_SET at t: IME_PIPE=1 at t+1, IME=1 at t+2 (one-instruction EI delay).
REQ-021 IME_CLR at t: IME=0 and IME_PIPE=0 at t+1. Wins over simultaneous or in-flight IME_SET.
REQ-022 IRQ_REQ is 0 outside REQ. IRQ_ACK outside REQ is ignored.

Reset
REQ-023 RES asserted: IE=0, IF=0, IME=0, IME_PIPE=0, state=IDLE, VEC_Q=8'h00, edge history=0. Outputs IRQ_REQ=0, IRQ_CLR=0, WAKE=0, DO_EN=0, VEC=8'h00.
REQ-024 RES mid-handshake (REQ/ACKD) SHALL abort to IDLE with no IF clear and no IRQ_CLR pulse.

Configuration
REQ-025 Macro IRQ_EDGE_DETECT_EN:
- Defined: IF[i] sets on IRQ_TRIG[i] rising edge (registered prev=0, cur=1). High trigger at reset release counts as an edge.
- Undefined: IF[i] sets every cycle IRQ_TRIG[i]=1 (level), and a clear while still high is re-set next edge.

Structure
REQ-026 Package irq_pkg SHALL hold the state enum (IDLE, REQ, ACKD), default VEC_BASE/VEC_STRIDE/IE_ADDR/IF_ADDR constants, and MAX_IRQ=8.
REQ-027 Sub-module irq_prio_enc (NUM_IRQ-parametrised): outputs any, index, one-hot of lowest set bit.

Verification
REQ-028 NUM_IRQ=5, IE=5'h1F, IME=1. Pulse IRQ_TRIG=5'b00110 -> IRQ_REQ=1, VEC=8'h48. ACK -> IRQ_CLR=5'b00010, IF=5'b00100, IME=0.
REQ-029 IME_SET at cycle 10, IE=1, IF=1 -> IRQ_REQ=0 at 10..11, IRQ_REQ=1 from cycle 13 (IDLE->REQ at edge 12).
REQ-030 In REQ write IF=0, then ACK -> VEC_Q=8'h00, IRQ_CLR=0, IME=0.
REQ-031 Same cycle: trigger bit 2 and ACK of winner bit 2 -> IF[2] stays 1, IRQ_CLR=5'b00100.
REQ-032 IME=0, IE=1, trigger bit 0 -> WAKE=1, IRQ_REQ=0. Read IF_ADDR -> DO=8'hE1.
REQ-033 RES asserted in REQ -> next cycle IRQ_REQ=0, IE=IF=0, VEC=8'h00. Trigger held high across release -> IF set only with IRQ_EDGE_DETECT_EN or level mode.
